pdp_mem_arbiter: RTL
====================

// Module: pdp_mem_arbiter
// PURPOSE
//  Shares one single-port PDP-8 memory between three requesters: IFU fetch read, exec operand read, exec write.
//  Sits between instr_decode/instr_exec and the memory array; replaces the dual-port memory_pdp model.
//  Sequences each access: arbitration, command issue, read-latency wait, response.
//  Includes an IFU starvation guard so instruction fetch cannot be locked out by exec traffic.
// PARAMETERS
//  ADDR_WIDTH    12  word address width (`ADDR_WIDTH)
//  DATA_WIDTH    12  data word width (`DATA_WIDTH)
//  MEM_RD_LAT    1   cycles from mem_en (read) to valid mem_rdata; legal range 1..7
//  STARVE_LIMIT  4   consecutive IFU arbitration losses before the IFU is forced to win
// PORTS
//  clk            in   1           system clock, all logic on rising edge
//  reset          in   1           synchronous, active-high reset
//  ifu_rd_req     in   1           IFU read request; held with addr until gnt
//  ifu_rd_addr    in   ADDR_WIDTH  IFU read address
//  ifu_rd_gnt     out  1           1-cycle pulse: IFU request accepted
//  ifu_rd_valid   out  1           1-cycle pulse: ifu_rd_data valid
//  ifu_rd_data    out  DATA_WIDTH  IFU read data (held until next valid)
//  exec_rd_req    in   1           exec read request
//  exec_rd_addr   in   ADDR_WIDTH  exec read address
//  exec_rd_gnt    out  1           1-cycle pulse: exec read accepted
//  exec_rd_valid  out  1           1-cycle pulse: exec_rd_data valid
//  exec_rd_data   out  DATA_WIDTH  exec read data (held until next valid)
//  exec_wr_req    in   1           exec write request
//  exec_wr_addr   in   ADDR_WIDTH  write address
//  exec_wr_data   in   DATA_WIDTH  write data
//  exec_wr_gnt    out  1           1-cycle pulse: write issued to memory this cycle
//  mem_en         out  1           memory access strobe
//  mem_we         out  1           1 = write, 0 = read (qualified by mem_en)
//  mem_addr       out  ADDR_WIDTH  memory address
//  mem_wdata      out  DATA_WIDTH  memory write data
//  mem_rdata      in   DATA_WIDTH  memory read data, MEM_RD_LAT cycles after read mem_en
//  busy           out  1           high in any state other than IDLE
//  perf_conflicts out  16          arbitration cycles with >=2 requests (PDP_ARB_PERF_EN)
//  perf_boosts    out  16          starvation-forced IFU grants (PDP_ARB_PERF_EN)
// BEHAVIOUR
//  - Reset: state IDLE. All gnt/valid/mem_en/mem_we/busy = 0. Data, addr, wdata outputs = 0. Loss counter and perf counters = 0.
//  - Reset mid-operation drops the in-flight read; no valid is produced for it.
//  - FSM: IDLE -> ISSUE -> (read) WAIT -> RESP -> IDLE; (write) ISSUE -> IDLE.
//  - IDLE: requests are sampled only here. If any req is high, the winner is latched and the FSM goes to ISSUE.
//  - ISSUE (1 cycle): winner gnt=1, mem_en=1, mem_we/addr/wdata from the latched winner. Requester drops req at the next edge.
//  - WAIT: counts MEM_RD_LAT-1 cycles (zero cycles when MEM_RD_LAT=1).
//  - RESP (1 cycle): mem_rdata is registered into the winner's *_rd_data; the winner's *_rd_valid pulses 1 cycle later, in IDLE.
//  - Latency: read req seen in IDLE at T -> gnt at T+1 -> valid at T+2+MEM_RD_LAT. Write: gnt/mem_en at T+1.
//  - Priority: exec_wr > exec_rd > ifu_rd. When loss_cnt == STARVE_LIMIT, IFU wins instead (boost).
//  - loss_cnt increments when IFU req is pending and another source is granted. It clears on any IFU grant and saturates at STARVE_LIMIT.
//  - Requests raised outside IDLE are not lost; they wait, held by the requester.
//  - Only one access is in flight at a time; no reordering.
//  - Write then read to the same address: the read returns the new data (strictly serialized).
// CONFIGURATION
//  PDP_ARB_PERF_EN defined:
//   - perf_conflicts increments on each IDLE arbitration with >=2 reqs.
//   - perf_boosts increments on each boosted IFU grant.
//   - Both counters saturate at 16'hFFFF and clear on reset.
//  PDP_ARB_PERF_EN undefined: no counter flops; perf_* tied to 0. The ports always exist.
// STRUCTURE
//  pdp8_pkg additions:
//   - arb_state_e {IDLE, ISSUE, WAIT, RESP}
//   - arb_src_e {SRC_IFU, SRC_EXRD, SRC_EXWR}
//   - ARB_PERF_W = 16
//  Sub-module pdp_arb_sel: combinational priority + boost winner select.
//   - inputs: 3 reqs, boost
//   - outputs: arb_src_e winner, any_req
// TESTING
//  1. Single IFU read, addr 12'o0200, mem holds 12'o7402, LAT=1: gnt at T+1, ifu_rd_valid at T+3, data 12'o7402.
//  2. All three reqs at T: exec_wr granted first, then exec_rd, then ifu_rd; perf_conflicts=2 (PERF_EN).
//  3. exec_wr 12'o1234 to 12'o0050 then exec_rd of 12'o0050: exec_rd_data = 12'o1234.
//  4. IFU req held while exec_rd continuously re-requests: IFU granted on the 5th arbitration (STARVE_LIMIT=4); perf_boosts=1.
//  5. reset asserted in WAIT with MEM_RD_LAT=3: next cycle all outputs 0, state IDLE, no rd_valid ever appears.
//  6. Build without PDP_ARB_PERF_EN, rerun test 2: perf_conflicts/perf_boosts stay 0; grant order unchanged.

Source files
------------

// File: rtl/pdp_mem_arbiter_pkg.sv
// Shared types for the PDP-8 single-port memory arbiter.
// Saturating counter helper is used by the optional perf counters.
package pdp_mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic [1:0] {SRC_IFU, SRC_EXRD, SRC_EXWR} arb_src_e;

  localparam int ARB_PERF_W = 16;

  function automatic logic [ARB_PERF_W-1:0] sat_inc(input logic [ARB_PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pdp_arb_sel.sv
// Combinational winner select: exec write > exec read > IFU fetch,
// except that a pending IFU fetch wins outright while boost is asserted.
module pdp_arb_sel
  import pdp_mem_arbiter_pkg::*;
(
  input  logic     i_ifu_req,
  input  logic     i_exrd_req,
  input  logic     i_exwr_req,
  input  logic     i_boost,
  output arb_src_e o_winner,
  output logic     o_any_req
);

  always_comb begin
    o_any_req = i_ifu_req | i_exrd_req | i_exwr_req;
    o_winner  = SRC_IFU;
    if (i_boost && i_ifu_req) begin
      o_winner = SRC_IFU;
    end else if (i_exwr_req) begin
      o_winner = SRC_EXWR;
    end else if (i_exrd_req) begin
      o_winner = SRC_EXRD;
    end
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Shares one single-port PDP-8 memory between IFU fetch, exec read and exec write.
// Define PDP_ARB_PERF_EN to build the conflict/boost performance counters.
//
// state | meaning
// IDLE  | sample requests, latch winner
// ISSUE | drive memory command, pulse winner's gnt
// WAIT  | remaining read latency beyond the first cycle
// RESP  | capture mem_rdata for the winner
module pdp_mem_arbiter
  import pdp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int MEM_RD_LAT   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_rd_gnt,
  output logic                  ifu_rd_valid,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                  exec_rd_gnt,
  output logic                  exec_rd_valid,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_gnt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [ARB_PERF_W-1:0] perf_conflicts,
  output logic [ARB_PERF_W-1:0] perf_boosts
);

  localparam int                LOSS_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(STARVE_LIMIT);
  localparam logic [2:0]        WAIT_LOAD = (MEM_RD_LAT > 1) ? 3'(MEM_RD_LAT - 2) : 3'd0;

  arb_state_e             r_state, w_next_state;
  arb_src_e               r_src, w_win;
  logic                   w_any_req, w_boost;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [2:0]             r_wait_cnt;
  logic [LOSS_W-1:0]      r_loss_cnt;
  logic                   r_ifu_rd_valid, r_exec_rd_valid;
  logic [DATA_WIDTH-1:0]  r_ifu_rd_data, r_exec_rd_data;

  assign w_boost = (r_loss_cnt == LOSS_MAX);

  pdp_arb_sel u_sel (
    .i_ifu_req  (ifu_rd_req),
    .i_exrd_req (exec_rd_req),
    .i_exwr_req (exec_wr_req),
    .i_boost    (w_boost),
    .o_winner   (w_win),
    .o_any_req  (w_any_req)
  );

  always_comb begin
    w_next_state = r_state;
    ifu_rd_gnt   = 1'b0;
    exec_rd_gnt  = 1'b0;
    exec_wr_gnt  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: if (w_any_req) w_next_state = ISSUE;
      ISSUE: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        mem_addr    = r_addr;
        if (r_we) mem_wdata = r_wdata;
        ifu_rd_gnt  = (r_src == SRC_IFU);
        exec_rd_gnt = (r_src == SRC_EXRD);
        exec_wr_gnt = (r_src == SRC_EXWR);
        if (r_we)                 w_next_state = IDLE;
        else if (MEM_RD_LAT == 1) w_next_state = RESP;
        else                      w_next_state = WAIT;
      end
      WAIT:    if (r_wait_cnt == 3'd0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_src           <= SRC_IFU;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wait_cnt      <= '0;
      r_loss_cnt      <= '0;
      r_ifu_rd_valid  <= 1'b0;
      r_exec_rd_valid <= 1'b0;
      r_ifu_rd_data   <= '0;
      r_exec_rd_data  <= '0;
    end else begin
      r_state         <= w_next_state;
      r_ifu_rd_valid  <= 1'b0;
      r_exec_rd_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_any_req) begin
          r_src   <= w_win;
          r_we    <= (w_win == SRC_EXWR);
          r_wdata <= exec_wr_data;
          case (w_win)
            SRC_EXWR: r_addr <= exec_wr_addr;
            SRC_EXRD: r_addr <= exec_rd_addr;
            default:  r_addr <= ifu_rd_addr;
          endcase
          // Losses are counted only while a fetch is actually waiting.
          if (w_win == SRC_IFU)              r_loss_cnt <= '0;
          else if (ifu_rd_req && !w_boost)   r_loss_cnt <= r_loss_cnt + 1'b1;
        end
        ISSUE: r_wait_cnt <= WAIT_LOAD;
        WAIT:  r_wait_cnt <= r_wait_cnt - 1'b1;
        RESP: begin
          if (r_src == SRC_IFU) begin
            r_ifu_rd_data  <= mem_rdata;
            r_ifu_rd_valid <= 1'b1;
          end else begin
            r_exec_rd_data  <= mem_rdata;
            r_exec_rd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ifu_rd_valid  = r_ifu_rd_valid;
  assign ifu_rd_data   = r_ifu_rd_data;
  assign exec_rd_valid = r_exec_rd_valid;
  assign exec_rd_data  = r_exec_rd_data;

`ifdef PDP_ARB_PERF_EN
  logic [ARB_PERF_W-1:0] r_perf_conflicts, r_perf_boosts;
  logic                  w_conflict;

  assign w_conflict = (ifu_rd_req & exec_rd_req) | (ifu_rd_req & exec_wr_req) |
                      (exec_rd_req & exec_wr_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_conflicts <= '0;
      r_perf_boosts    <= '0;
    end else if (r_state == IDLE) begin
      if (w_conflict) r_perf_conflicts <= sat_inc(r_perf_conflicts);
      if (w_boost && ifu_rd_req) r_perf_boosts <= sat_inc(r_perf_boosts);
    end
  end

  assign perf_conflicts = r_perf_conflicts;
  assign perf_boosts    = r_perf_boosts;
`else
  assign perf_conflicts = '0;
  assign perf_boosts    = '0;
`endif

endmodule
